// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: EXE-stage integer unit with single-cycle ALU ops and a 1-bit/cycle
// multiply/divide engine, valid/ready on both sides, synchronous flush.
//
// state | meaning
// IDLE  | nothing in flight, ready for an op
// BUSY  | MDU iterating, exactly WIDTH cycles
// DONE  | result/flags held until out_ready
module alu_mdu_seq #(
  parameter int WIDTH  = 32,
  parameter int IMM_W  = 16,
  parameter int SEXT_W = 12,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             i_type,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             eq,
  output logic             lt,
  output logic             ltu,
  output logic             overflow,
  output logic             div_zero,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;
  localparam logic [2:0] OP_ADD = 3'b110, OP_AND = 3'b111, OP_OR  = 3'b101, OP_XOR = 3'b011,
                         OP_NOT = 3'b000, OP_SHL = 3'b001, OP_SHR = 3'b010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0]   imm_z, imm_s, b_sel, sum, fast_res, mag_a, mag_b;
  logic [WIDTH:0]     diff;
  logic [SHAMT_W-1:0] sh;
  logic               fast_ovf, fast_dz, fast_ill, illegal_op, is_div, b_zero, min_neg1;
  logic               fast, accept;

  logic [WIDTH-1:0]   hi, lo, mb;
  logic [2:0]         mop;
  logic               neg_q, neg_r;
  logic [SHAMT_W-1:0] cnt;

  logic [WIDTH:0]       mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0]     it_hi, it_lo, quo_f, rem_f, fin_res;
  logic [2*WIDTH-1:0]   prod, prod_s;
  logic                 div_ge, is_mul;

  assign imm_z = WIDTH'(imm);
  assign imm_s = WIDTH'($signed(imm[SEXT_W-1:0]));
  assign b_sel = (!op[3] && i_type) ? ((op[2:0] == OP_ADD) ? imm_s : imm_z) : b;
  assign sh    = i_type ? imm[SHAMT_W-1:0] : b[SHAMT_W-1:0];
  assign sum   = a + b_sel;
  assign diff  = {1'b0, a} - {1'b0, b_sel};

  assign illegal_op = op[3] && (op[2:1] == 2'b11);
  assign is_div     = op[3] && (op[2:1] == 2'b01 || op[2:1] == 2'b10);
  assign b_zero     = (b == '0);
  assign min_neg1   = is_div && !op[2] && (a == {1'b1, {MSB{1'b0}}}) && (&b);
  assign fast       = !op[3] || illegal_op || (is_div && (b_zero || min_neg1));

  // ops 000..011 on the MDU side are the signed ones
  assign mag_a = (!op[2] && a[MSB]) ? -a : a;
  assign mag_b = (!op[2] && b[MSB]) ? -b : b;

  assign in_ready  = ((state == IDLE) || (state == DONE && out_ready)) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  always_comb begin
    fast_res = '0;
    fast_ovf = 1'b0;
    fast_dz  = 1'b0;
    fast_ill = 1'b0;
    if (!op[3]) begin
      case (op[2:0])
        OP_ADD: begin
          fast_res = sum;
          fast_ovf = (a[MSB] == b_sel[MSB]) && (sum[MSB] != a[MSB]);
        end
        OP_AND:  fast_res = a & b_sel;
        OP_OR:   fast_res = a | b_sel;
        OP_XOR:  fast_res = a ^ b_sel;
        OP_NOT:  fast_res = ~a;
        OP_SHL:  fast_res = i_type ? imm_z : (a << sh);
        OP_SHR:  fast_res = i_type ? ((a << IMM_W) | imm_z) : (a >> sh);
        default: fast_res = $unsigned($signed(a) >>> sh);
      endcase
    end else if (illegal_op) begin
      fast_ill = 1'b1;
    end else if (is_div && b_zero) begin
      fast_dz  = 1'b1;
      fast_res = op[0] ? a : '1;
    end else if (min_neg1) begin
      fast_ovf = 1'b1;
      fast_res = op[0] ? '0 : a;
    end
  end

  // one iteration of shift-add multiply / restoring divide on magnitudes
  assign is_mul   = (mop[2:1] == 2'b00);
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
  assign div_sh   = {hi, lo[MSB]};
  assign div_diff = div_sh - {1'b0, mb};
  assign div_ge   = !div_diff[WIDTH];
  assign it_hi    = is_mul ? mul_sum[WIDTH:1] : (div_ge ? div_diff[MSB:0] : div_sh[MSB:0]);
  assign it_lo    = is_mul ? {mul_sum[0], lo[MSB:1]} : {lo[MSB-1:0], div_ge};
  assign prod     = {it_hi, it_lo};
  assign prod_s   = neg_q ? -prod : prod;
  assign quo_f    = neg_q ? -it_lo : it_lo;
  assign rem_f    = neg_r ? -it_hi : it_hi;

  always_comb begin
    fin_res = quo_f;
    if (is_mul)      fin_res = mop[0] ? prod_s[2*WIDTH-1:WIDTH] : prod_s[MSB:0];
    else if (mop[0]) fin_res = rem_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_n = fast ? DONE : BUSY;
        BUSY:    if (cnt == '0) state_n = DONE;
        DONE: begin
          if (accept)         state_n = fast ? DONE : BUSY;
          else if (out_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      eq       <= 1'b0;
      lt       <= 1'b0;
      ltu      <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mb       <= '0;
      mop      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      eq       <= (diff[MSB:0] == '0);
      ltu      <= diff[WIDTH];
      lt       <= (a[MSB] != b_sel[MSB]) ? a[MSB] : diff[MSB];
      overflow <= fast_ovf;
      div_zero <= fast_dz;
      illegal  <= fast_ill;
      if (fast) begin
        result <= fast_res;
      end else begin
        mop   <= op[2:0];
        hi    <= '0;
        lo    <= mag_a;
        mb    <= mag_b;
        neg_q <= !op[2] && (a[MSB] ^ b[MSB]);
        neg_r <= !op[2] && a[MSB];
        cnt   <= SHAMT_W'(WIDTH - 1);
      end
    end else if (state == BUSY && !flush) begin
      hi <= it_hi;
      lo <= it_lo;
      if (cnt == '0) result <= fin_res;
      else           cnt <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq: driver pushes model results, a negedge monitor
// pops them on every accepted output and checks value, flags, latency and hold stability.
module tb_alu_mdu_seq;
  localparam int W = 32;
  localparam int MDU_LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, i_type, out_ready;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic [15:0]   imm;
  logic          in_ready, out_valid, eq, lt, ltu, overflow, div_zero, illegal;
  logic [W-1:0]  result;
  logic [5:0]    flg_act;

  typedef struct {
    logic [W-1:0] res;
    logic [5:0]   flg;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  alu_mdu_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .i_type(i_type), .a(a), .b(b), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .eq(eq), .lt(lt), .ltu(ltu),
    .overflow(overflow), .div_zero(div_zero), .illegal(illegal)
  );

  assign flg_act = {eq, lt, ltu, overflow, div_zero, illegal};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // reference: plain integer arithmetic on the architectural rules
  function automatic exp_t model(input logic [3:0] o, input logic it, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [15:0] im, input int now);
    exp_t e;
    logic [W-1:0] bs;
    logic [4:0] sh;
    int ix, iy;
    longint s, p;
    logic ovf, dz, ill;
    bit slow;
    ovf = 0; dz = 0; ill = 0; slow = 0; e.res = '0;
    if (o[3] || !it)           bs = y;
    else if (o[2:0] == 3'b110) bs = {{20{im[11]}}, im[11:0]};
    else                       bs = {16'h0, im};
    sh = it ? im[4:0] : y[4:0];
    ix = x;
    iy = bs;
    if (!o[3]) begin
      case (o[2:0])
        3'b110: begin
          s = longint'(ix) + longint'(iy);
          e.res = x + bs;
          ovf = (s != longint'(int'(s)));
        end
        3'b111:  e.res = x & bs;
        3'b101:  e.res = x | bs;
        3'b011:  e.res = x ^ bs;
        3'b000:  e.res = ~x;
        3'b001:  e.res = it ? {16'h0, im} : x << sh;
        3'b010:  e.res = it ? {x[15:0], im} : x >> sh;
        default: e.res = 32'(ix >>> sh);
      endcase
    end else begin
      p = longint'(ix) * longint'(iy);
      case (o[2:0])
        3'b000: begin e.res = p[31:0];  slow = 1; end
        3'b001: begin e.res = p[63:32]; slow = 1; end
        3'b010, 3'b011: begin
          if (y == 0) begin
            dz = 1; e.res = o[0] ? x : 32'hFFFF_FFFF;
          end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            ovf = 1; e.res = o[0] ? 32'h0 : x;
          end else begin
            slow = 1; e.res = o[0] ? 32'(ix % iy) : 32'(ix / iy);
          end
        end
        3'b100, 3'b101: begin
          if (y == 0) begin
            dz = 1; e.res = o[0] ? x : 32'hFFFF_FFFF;
          end else begin
            slow = 1; e.res = o[0] ? x % y : x / y;
          end
        end
        default: ill = 1;
      endcase
    end
    e.flg = {x == bs, ix < iy, x < bs, ovf, dz, ill};
    e.due = now + (slow ? MDU_LAT : 1);
    return e;
  endfunction

  // mode 0: out_ready=1, mode 1: random out_ready, mode 2: out_ready=0
  task automatic issue(input logic [3:0] o, input logic it, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [15:0] im, input int mode);
    int tries = 0;
    bit done = 0;
    op = o; i_type = it; a = x; b = y; imm = im; in_valid = 1'b1;
    out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(o, it, x, y, im, cyc));
        done = 1;
      end else begin
        tries++;
        if (tries > 100) begin
          chk("accept_timeout", 64'(in_ready), 1);
          done = 1;
        end
      end
      @(posedge clk); #1;
      if (!done && mode == 1) out_ready = (tries > 3) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  logic [W+5:0] held;
  bit           holding = 0;
  bit           seen = 0;
  int           seen_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (!seen) begin
        seen = 1;
        seen_cyc = cyc;
      end
      if (holding) chk("hold_stable", {result, flg_act}, held);
      if (out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("flags", flg_act, e.flg);
          chk("latency", 64'(seen_cyc), 64'(e.due));
        end
        seen = 0;
        holding = 0;
      end else begin
        holding = 1;
        held = {result, flg_act};
      end
    end else begin
      seen = 0;
      holding = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, hi_rdy, n;
    logic [W-1:0] ra, rb;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; i_type = 1'b0;
    a = '0; b = '0; imm = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flg_act, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;

    issue(4'b0110, 1'b0, 32'h7FFF_FFFF, 32'h1, 16'h0, 0);
    issue(4'b0110, 1'b1, 32'h10, 32'h0, 16'h0FFF, 0);
    issue(4'b0010, 1'b1, 32'h1234_5678, 32'h0, 16'hABCD, 0);
    drain();

    issue(4'b1010, 1'b0, -32'sd7, 32'd2, 16'h0, 0);
    hi_rdy = 0; n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) hi_rdy++;
      n++;
    end
    chk("busy_in_ready", 64'(hi_rdy), 0);
    chk("busy_cycles", 64'(n), 64'(W));
    @(posedge clk); #1;
    issue(4'b1011, 1'b0, -32'sd7, 32'd2, 16'h0, 0);
    drain();

    issue(4'b1100, 1'b0, 32'h55, 32'h0, 16'h0, 0);
    issue(4'b1011, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0, 0);
    issue(4'b1001, 1'b0, -32'sd2, 32'd3, 16'h0, 0);
    issue(4'b1110, 1'b0, 32'h1, 32'h2, 16'h0, 0);
    drain();

    issue(4'b1000, 1'b0, -32'sd2, 32'd3, 16'h0, 2);
    repeat (MDU_LAT + 10) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    c0 = cyc;
    for (int k = 0; k < 8; k++)
      issue({1'b0, 3'($urandom_range(0, 7))}, 1'($urandom_range(0, 1)), $urandom, $urandom,
            16'($urandom), 0);
    chk("b2b_cycles", 64'(cyc - c0), 8);
    drain();

    issue(4'b1010, 1'b0, 32'd1000, 32'd7, 16'h0, 0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1; in_valid = 1'b1; op = 4'b0110; a = 32'd1; b = 32'd1;
    sb.delete();
    @(negedge clk);
    chk("flush_busy_in_ready", 64'(in_ready), 0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 0);
    chk("post_flush_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1 flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_idle_in_ready", 64'(in_ready), 0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_wins_out_valid", 64'(out_valid), 0);
    @(posedge clk); #1;
    issue(4'b1010, 1'b0, 32'd1000, 32'd7, 16'h0, 0);
    drain();

    issue(4'b1100, 1'b0, 32'hDEAD_BEEF, 32'd13, 16'h0, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midbusy_rst_out_valid", 64'(out_valid), 0);
    chk("midbusy_rst_result", result, 0);
    chk("midbusy_rst_flags", flg_act, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    issue(4'b1101, 1'b0, 32'hDEAD_BEEF, 32'd13, 16'h0, 0);
    drain();

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ra, rb, 16'($urandom), 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
